// File: rtl/gpu_pkg.sv
// gpu_pkg: shared control-word layout, fill FSM states and
// framebuffer defaults for the GPU fill path.
package gpu_pkg;

  localparam int GO_BIT = 0;
  localparam int OP_BIT = 1;
  localparam int W_LSB  = 2;
  localparam int W_BITS = 10;
  localparam int H_LSB  = 12;
  localparam int H_BITS = 10;

  localparam int DEF_FB_WIDTH  = 320;
  localparam int DEF_FB_HEIGHT = 240;

  localparam int CRD_BITS = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_DONE
  } fill_state_t;

endpackage

// File: rtl/gpu_fill_addr_gen.sv
// gpu_fill_addr_gen: row-major pixel walker with row_base
// accumulation and framebuffer bounds check.
module gpu_fill_addr_gen
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH  = DEF_FB_WIDTH,
  parameter int FB_HEIGHT = DEF_FB_HEIGHT,
  parameter int AW        = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start,
  input  logic                step,
  input  logic [CRD_BITS-1:0] x0,
  input  logic [CRD_BITS-1:0] y0,
  input  logic [W_BITS-1:0]   w,
  input  logic [H_BITS-1:0]   h,
  output logic [AW-1:0]       addr,
  output logic                in_bounds,
  output logic                last
);

  localparam int RBW = AW + 1;
  localparam logic [RBW-1:0] FBW = RBW'(FB_WIDTH);

  logic [CRD_BITS-1:0] x_q;
  logic [CRD_BITS-1:0] y_q;
  logic [W_BITS-1:0]   col_q;
  logic [H_BITS-1:0]   row_q;
  logic [RBW-1:0]      rb_q;
  logic [RBW-1:0]      y0_base;
  logic [RBW-1:0]      sum;
  logic                row_end;

  // Rows past FB_HEIGHT may wrap row_base; they are never written.
  assign y0_base = RBW'(y0) * FBW;
  assign sum     = rb_q + RBW'(x_q);
  assign addr    = sum[AW-1:0];
  assign row_end = (col_q == w - W_BITS'(1));
  assign last    = row_end && (row_q == h - H_BITS'(1));

  assign in_bounds = (x_q < CRD_BITS'(FB_WIDTH)) &&
                     (y_q < CRD_BITS'(FB_HEIGHT));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
      row_q <= '0;
      rb_q  <= '0;
    end else if (start) begin
      x_q   <= x0;
      y_q   <= y0;
      col_q <= '0;
      row_q <= '0;
      rb_q  <= y0_base;
    end else if (step) begin
      if (row_end) begin
        x_q   <= x0;
        y_q   <= y_q + CRD_BITS'(1);
        col_q <= '0;
        row_q <= row_q + H_BITS'(1);
        rb_q  <= rb_q + FBW;
      end else begin
        x_q   <= x_q + CRD_BITS'(1);
        col_q <= col_q + W_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/gpu_fill_ctrl.sv
// gpu_fill_ctrl: pixel / rectangle fill sequencer feeding the
// framebuffer write arbiter under a valid/ready handshake.
module gpu_fill_ctrl
  import gpu_pkg::*;
#(
  parameter int FB_WIDTH   = DEF_FB_WIDTH,
  parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
  parameter int INDEX_BITS = 8,
  parameter int REG_WIDTH  = 32,
  localparam int FB_ADDR_BITS = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [REG_WIDTH-1:0]    cp_x_i,
  input  logic [REG_WIDTH-1:0]    cp_y_i,
  input  logic [REG_WIDTH-1:0]    index_i,
  input  logic [REG_WIDTH-1:0]    ctrl_i,
  output logic [FB_ADDR_BITS-1:0] fb_addr_o,
  output logic [INDEX_BITS-1:0]   fb_data_o,
  output logic                    fb_we_o,
  input  logic                    fb_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    clip_o
);

  fill_state_t state_q, state_d;

  logic                  go_prev_q;
  logic [CRD_BITS-1:0]   x0_q;
  logic [CRD_BITS-1:0]   y0_q;
  logic [INDEX_BITS-1:0] col_q;
  logic [W_BITS-1:0]     w_q;
  logic [H_BITS-1:0]     h_q;
  logic                  clip_q;

  logic go_rise;
  logic latch;
  logic start;
  logic step;
  logic clip_set;
  logic in_bounds;
  logic last;

  logic [FB_ADDR_BITS-1:0] addr;
  logic                    unused_bits;

  assign unused_bits = ^{cp_x_i[REG_WIDTH-1:16],
                         cp_y_i[REG_WIDTH-1:16],
                         index_i[REG_WIDTH-1:INDEX_BITS],
                         ctrl_i[REG_WIDTH-1:H_LSB+H_BITS]};

  assign go_rise = ctrl_i[GO_BIT] && !go_prev_q;

  gpu_fill_addr_gen #(
    .FB_WIDTH  (FB_WIDTH),
    .FB_HEIGHT (FB_HEIGHT),
    .AW        (FB_ADDR_BITS)
  ) u_addr_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start     (start),
    .step      (step),
    .x0        (x0_q),
    .y0        (y0_q),
    .w         (w_q),
    .h         (h_q),
    .addr      (addr),
    .in_bounds (in_bounds),
    .last      (last)
  );

  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    start    = 1'b0;
    step     = 1'b0;
    clip_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go_rise) begin
          latch   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        start   = 1'b1;
        state_d = (w_q == '0 || h_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        // Clipped pixels retire in one cycle without a write.
        if (!in_bounds) begin
          clip_set = 1'b1;
          step     = 1'b1;
        end else if (fb_ready_i) begin
          step = 1'b1;
        end
        if (step && last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      go_prev_q <= 1'b1;
      x0_q      <= '0;
      y0_q      <= '0;
      col_q     <= '0;
      w_q       <= '0;
      h_q       <= '0;
      clip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      go_prev_q <= ctrl_i[GO_BIT];
      if (latch) begin
        x0_q   <= {1'b0, cp_x_i[15:0]};
        y0_q   <= {1'b0, cp_y_i[15:0]};
        col_q  <= index_i[INDEX_BITS-1:0];
        w_q    <= ctrl_i[OP_BIT] ? ctrl_i[W_LSB +: W_BITS]
                                 : W_BITS'(1);
        h_q    <= ctrl_i[OP_BIT] ? ctrl_i[H_LSB +: H_BITS]
                                 : H_BITS'(1);
        clip_q <= 1'b0;
      end else if (clip_set) begin
        clip_q <= 1'b1;
      end
    end
  end

  assign fb_we_o   = (state_q == S_RUN) && in_bounds;
  assign fb_addr_o = addr;
  assign fb_data_o = col_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign clip_o    = clip_q;

endmodule

// File: tb/tb_gpu_fill_ctrl.sv
// tb_gpu_fill_ctrl: directed fill commands with a write/done
// scoreboard checked by an independent bus monitor.
module tb_gpu_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] cp_x_i, cp_y_i, index_i, ctrl_i;
  logic [16:0] fb_addr_o;
  logic [7:0]  fb_data_o;
  logic        fb_we_o, fb_ready_i;
  logic        busy_o, done_o, clip_o;

  always #5 clk = ~clk;

  gpu_fill_ctrl #(
    .FB_WIDTH   (320),
    .FB_HEIGHT  (240),
    .INDEX_BITS (8),
    .REG_WIDTH  (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cp_x_i     (cp_x_i),
    .cp_y_i     (cp_y_i),
    .index_i    (index_i),
    .ctrl_i     (ctrl_i),
    .fb_addr_o  (fb_addr_o),
    .fb_data_o  (fb_data_o),
    .fb_we_o    (fb_we_o),
    .fb_ready_i (fb_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .clip_o     (clip_o)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t wq[$];
  int   dq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)",
               nm, act, expv, cyc);
    end
  endtask

  task automatic exp_w(int a, int d, int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    wq.push_back(e);
  endtask

  // Monitor: pops one expectation per accepted write / done pulse.
  logic        stall_p = 1'b0;
  logic [16:0] st_addr;
  logic [7:0]  st_data;

  always @(negedge clk) begin : mon
    exp_t e;
    if (stall_p) begin
      chk("stall_we", int'(fb_we_o), 1);
      chk("stall_addr", int'(fb_addr_o), int'(st_addr));
      chk("stall_data", int'(fb_data_o), int'(st_data));
    end
    stall_p = fb_we_o && !fb_ready_i;
    st_addr = fb_addr_o;
    st_data = fb_data_o;
    if (fb_we_o && fb_ready_i) begin
      if (wq.size() == 0) begin
        chk("unexpected_write_addr", int'(fb_addr_o), -1);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", int'(fb_addr_o), e.addr);
        chk("wr_data", int'(fb_data_o), e.data);
        if (e.cyc >= 0) chk("wr_cyc", cyc, e.cyc);
      end
    end
    if (done_o) begin
      if (dq.size() == 0) chk("unexpected_done_cyc", cyc, -1);
      else chk("done_cyc", cyc, dq.pop_front());
    end
  end

  // Returns during cycle n, the cycle in which the go edge is sampled.
  task automatic go_cmd(int x, int y, int idx, int cw, output int n);
    @(posedge clk); #1;
    cp_x_i  = x;
    cp_y_i  = y;
    index_i = idx;
    ctrl_i  = cw & ~32'h1;
    @(posedge clk); #1;
    ctrl_i = cw | 32'h1;
    n = cyc;
  endtask

  task automatic wait_idle(string nm, int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (!busy_o) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: timeout busy=%0d want 0", nm, busy_o);
    end
  endtask

  task automatic drop_go_and_wait(string nm);
    @(posedge clk); #1;
    ctrl_i[0] = 1'b0;
    chk({nm, "_busy_setup"}, int'(busy_o), 1);
    wait_idle(nm, 200);
  endtask

  int n;

  initial begin
    rst_i      = 1'b1;
    cp_x_i     = '0;
    cp_y_i     = '0;
    index_i    = '0;
    ctrl_i     = 32'h1;
    fb_ready_i = 1'b1;

    // Reset state, with go held high throughout reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", int'(fb_we_o), 0);
    chk("rst_addr", int'(fb_addr_o), 0);
    chk("rst_data", int'(fb_data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_clip", int'(clip_o), 0);
    rst_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("go_held_busy", int'(busy_o), 0);
    ctrl_i = '0;

    // Single pixel at (10,2).
    go_cmd(10, 2, 'h5A, 32'h0, n);
    exp_w(650, 'h5A, n + 2);
    dq.push_back(n + 3);
    drop_go_and_wait("single");
    chk("single_clip", int'(clip_o), 0);

    // 4x2 rectangle straddling the right edge.
    go_cmd(318, 0, 'h33, 32'h2012, n);
    exp_w(318, 'h33, n + 2);
    exp_w(319, 'h33, n + 3);
    exp_w(638, 'h33, n + 6);
    exp_w(639, 'h33, n + 7);
    dq.push_back(n + 10);
    drop_go_and_wait("rect");
    chk("rect_clip", int'(clip_o), 1);

    // 3x1 at (0,0) under ready pattern 1,0,0,1,1.
    go_cmd(0, 0, 'h77, 32'h100E, n);
    exp_w(0, 'h77, n + 2);
    exp_w(1, 'h77, n + 5);
    exp_w(2, 'h77, n + 6);
    dq.push_back(n + 7);
    @(posedge clk); #1;
    ctrl_i[0] = 1'b0;
    @(posedge clk); #1; fb_ready_i = 1'b1;
    @(posedge clk); #1; fb_ready_i = 1'b0;
    @(posedge clk); #1; fb_ready_i = 1'b0;
    @(posedge clk); #1; fb_ready_i = 1'b1;
    @(posedge clk); #1; fb_ready_i = 1'b1;
    wait_idle("bp", 50);
    chk("bp_clip", int'(clip_o), 0);

    // Zero width: no writes, done two cycles after go.
    go_cmd(7, 7, 'h01, 32'h5002, n);
    dq.push_back(n + 2);
    drop_go_and_wait("zero");
    chk("zero_clip", int'(clip_o), 0);

    // 3x2 at (5,1) with go re-pulsed mid-command.
    go_cmd(5, 1, 'h11, 32'h200E, n);
    exp_w(325, 'h11, n + 2);
    exp_w(326, 'h11, n + 3);
    exp_w(327, 'h11, n + 4);
    exp_w(645, 'h11, n + 5);
    exp_w(646, 'h11, n + 6);
    exp_w(647, 'h11, n + 7);
    dq.push_back(n + 8);
    @(posedge clk); #1; ctrl_i[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; ctrl_i[0] = 1'b1;
    @(posedge clk); #1; ctrl_i[0] = 1'b0;
    wait_idle("gobusy", 50);
    repeat (4) @(posedge clk);
    #1;
    chk("gobusy_idle", int'(busy_o), 0);

    // 10x10 at (0,0), reset after the third write.
    go_cmd(0, 0, 'h42, 32'hA02A, n);
    exp_w(0, 'h42, n + 2);
    exp_w(1, 'h42, n + 3);
    exp_w(2, 'h42, n + 4);
    @(posedge clk); #1; ctrl_i[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_i = 1'b1;
    @(posedge clk); #1;
    chk("rstrun_we", int'(fb_we_o), 0);
    chk("rstrun_busy", int'(busy_o), 0);
    chk("rstrun_done", int'(done_o), 0);
    rst_i = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rstrun_idle", int'(busy_o), 0);

    chk("wq_empty", wq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
